pc_ras_unit: RTL and testbench
==============================

// Module: pc_ras_unit
// PURPOSE
//  Parametrised program-counter unit for picoMIPS-class cores: fetch address generator with stall,
//  absolute/PC-relative branches and call/return via an internal return-address stack (RAS).
//  Sits between the decoder/branch logic (ops) and instruction memory (pc).
//  Fully synchronous, single clock.
// PARAMETERS
//  PC_WIDTH   6  width of pc and of all addresses; arithmetic is modulo 2**PC_WIDTH
//  OFF_WIDTH  6  width of signed relative offset (two's complement, OFF_WIDTH <= PC_WIDTH)
//  RAS_DEPTH  4  return-address-stack entries (>=2, power of two)
// PORTS
//  clk            in   1                     clock, all state updates on rising edge
//  reset          in   1                     synchronous, active-high reset
//  pc_en          in   1                     advance enable; 0 = stall (hold all state)
//  branch_en      in   1                     taken branch/jump this cycle
//  call_en        in   1                     call: push return address and jump
//  ret_en         in   1                     return: pop RAS into pc
//  rel_mode       in   1                     1 = target is pc+offset, 0 = branch_target
//  branch_target  in   PC_WIDTH              absolute target
//  offset         in   OFF_WIDTH             signed relative offset
//  pc             out  PC_WIDTH              current fetch address (registered)
//  ras_count      out  $clog2(RAS_DEPTH)+1   valid RAS entries, 0..RAS_DEPTH
//  ras_empty      out  1                     ras_count==0
//  ras_full       out  1                     ras_count==RAS_DEPTH
//  ras_ovf        out  1                     sticky: call made while full
//  ras_unf        out  1                     sticky: return made while empty
// BEHAVIOUR
//  - Reset (sampled at clk edge): pc=0, ras_count=0, ras_ovf=0, ras_unf=0, pointer=0; entries don't-care.
//  - pc_en=0: pc, RAS, count, flags all hold; op inputs ignored.
//  - pc_en=1, priority ret_en > call_en > branch_en > increment; exactly one action per cycle:
//    ret:    non-empty -> pc<=top entry, count-1. Empty -> pc<=pc+1, ras_unf<=1, count stays 0.
//    call:   pc<=tgt; push pc+1 (wrapped). Full -> oldest entry overwritten (circular), count stays
//            RAS_DEPTH, ras_ovf<=1. Push/pop are LIFO on the most recent entries.
//    branch: pc<=tgt. Otherwise pc<=pc+1.
//  - tgt = rel_mode ? pc + sign_extend(offset) : branch_target; result truncated to PC_WIDTH (wraps).
//    Relative base is the current pc (address of the branching instruction), not pc+1.
//  - Increment wraps 2**PC_WIDTH-1 -> 0 with no flag.
//  - Latency: a qualifying op at edge N is visible on pc after edge N (1-cycle, registered); no comb
//    path from inputs to pc. ras_full/ras_empty decode registered count only.
//  - Sticky flags clear only on reset. Reset asserted mid-sequence discards RAS contents fully.
//  - Simultaneous call_en+ret_en: ret wins, no push occurs. rel_mode ignored when only ret/increment.
// TESTING
//  1 reset, pc_en=1, 5 idle cycles -> pc 0,1,2,3,4,5; ras_empty=1; flags 0.
//  2 pc=10, branch_en rel_mode=1 offset=6'h3C(-4) -> pc=6; pc=62 increment x2 -> 63,0.
//  3 pc=5 call tgt=20; pc=20 call tgt=40 -> count=2; ret -> pc=21; ret -> pc=6; ras_empty=1.
//  4 five calls from pc=1,11,21,31,41 (tgt=pc+10) -> count=4, ras_ovf=1; 4 rets -> 42,32,22,12;
//    5th ret -> pc=13, ras_unf=1.
//  5 pc_en=0 with branch_en/call_en held high 3 cycles -> pc and ras_count unchanged.
//  6 mid-call-chain (count=3) assert reset 1 cycle -> pc=0, count=0, flags 0; call_en+ret_en
//    together at count=0 -> ras_unf=1, no push.

Source files
------------

// File: rtl/pc_ras_unit.sv
// Program-counter unit with stall, absolute/relative branches and a
// circular return-address stack for call/return.
module pc_ras_unit #(
    parameter int PC_WIDTH  = 6,
    parameter int OFF_WIDTH = 6,
    parameter int RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         pc_en,
    input  logic                         branch_en,
    input  logic                         call_en,
    input  logic                         ret_en,
    input  logic                         rel_mode,
    input  logic [PC_WIDTH-1:0]          branch_target,
    input  logic [OFF_WIDTH-1:0]         offset,
    output logic [PC_WIDTH-1:0]          pc,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_empty,
    output logic                         ras_full,
    output logic                         ras_ovf,
    output logic                         ras_unf
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

    typedef enum logic [1:0] {
        ACT_INC,
        ACT_BR,
        ACT_CALL,
        ACT_RET
    } act_t;

    logic [PC_WIDTH-1:0] stack_q [RAS_DEPTH];
    logic [PW-1:0]       sp_q;
    logic [PW-1:0]       sp_dec;
    logic [CW-1:0]       cnt_q;
    logic                ovf_q;
    logic                unf_q;

    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] off_ext;
    logic [PC_WIDTH-1:0] tgt;
    logic [PC_WIDTH-1:0] top;
    act_t                act;

    assign pc_inc  = pc + PC_WIDTH'(1);
    assign off_ext = PC_WIDTH'($signed(offset));
    assign tgt     = rel_mode ? pc + off_ext : branch_target;
    assign sp_dec  = sp_q - PW'(1);
    assign top     = stack_q[sp_dec];

    assign ras_count = cnt_q;
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == FULL_CNT);
    assign ras_ovf   = ovf_q;
    assign ras_unf   = unf_q;

    // Priority ret > call > branch > increment.
    always_comb begin
        act = ACT_INC;
        if (ret_en)
            act = ACT_RET;
        else if (call_en)
            act = ACT_CALL;
        else if (branch_en)
            act = ACT_BR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= '0;
            sp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (pc_en) begin
            unique case (act)
                ACT_RET: begin
                    if (cnt_q == '0) begin
                        pc    <= pc_inc;
                        unf_q <= 1'b1;
                    end else begin
                        pc    <= top;
                        sp_q  <= sp_dec;
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ACT_CALL: begin
                    pc <= tgt;
                    // When full, sp already points at the oldest slot.
                    stack_q[sp_q] <= pc_inc;
                    sp_q          <= sp_q + PW'(1);
                    if (cnt_q == FULL_CNT)
                        ovf_q <= 1'b1;
                    else
                        cnt_q <= cnt_q + CW'(1);
                end
                ACT_BR:  pc <= tgt;
                ACT_INC: pc <= pc_inc;
                default: pc <= pc_inc;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed self-checking bench for pc_ras_unit.
// Each task drives one scenario and checks against hand-computed values.
module tb_pc_ras_unit;

    logic       clk;
    logic       reset;
    logic       pc_en;
    logic       branch_en;
    logic       call_en;
    logic       ret_en;
    logic       rel_mode;
    logic [5:0] branch_target;
    logic [5:0] offset;
    logic [5:0] pc;
    logic [2:0] ras_count;
    logic       ras_empty;
    logic       ras_full;
    logic       ras_ovf;
    logic       ras_unf;

    int checks;
    int errors;

    pc_ras_unit #(
        .PC_WIDTH (6),
        .OFF_WIDTH(6),
        .RAS_DEPTH(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_en        (pc_en),
        .branch_en    (branch_en),
        .call_en      (call_en),
        .ret_en       (ret_en),
        .rel_mode     (rel_mode),
        .branch_target(branch_target),
        .offset       (offset),
        .pc           (pc),
        .ras_count    (ras_count),
        .ras_empty    (ras_empty),
        .ras_full     (ras_full),
        .ras_ovf      (ras_ovf),
        .ras_unf      (ras_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        branch_en     = 1'b0;
        call_en       = 1'b0;
        ret_en        = 1'b0;
        rel_mode      = 1'b0;
        branch_target = '0;
        offset        = '0;
    endtask

    task automatic do_reset();
        idle();
        pc_en = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic jump(input logic [5:0] t);
        idle();
        branch_en     = 1'b1;
        branch_target = t;
        step();
        idle();
    endtask

    task automatic call(input logic [5:0] t);
        idle();
        call_en       = 1'b1;
        branch_target = t;
        step();
        idle();
    endtask

    task automatic ret();
        idle();
        ret_en = 1'b1;
        step();
        idle();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (pc !== 6'd0 || ras_count !== 3'd0 || ras_empty !== 1'b1 ||
            ras_full !== 1'b0 || ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin
            errors++;
            $display("FAIL reset: pc=%0d cnt=%0d e=%b f=%b o=%b u=%b, want 0 0 1 0 0 0",
                     pc, ras_count, ras_empty, ras_full, ras_ovf, ras_unf);
        end
        for (int i = 1; i <= 5; i++) begin
            step();
            checks++;
            if (pc !== 6'(i) || ras_empty !== 1'b1 || ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin
                errors++;
                $display("FAIL idle_inc: pc=%0d e=%b o=%b u=%b, want pc=%0d 1 0 0",
                         pc, ras_empty, ras_ovf, ras_unf, i);
            end
        end
    endtask

    task automatic test_branch();
        do_reset();
        jump(6'd10);
        checks++;
        if (pc !== 6'd10) begin
            errors++;
            $display("FAIL br_abs: pc=%0d want 10", pc);
        end
        branch_en = 1'b1;
        rel_mode  = 1'b1;
        offset    = 6'h3C;
        step();
        idle();
        checks++;
        if (pc !== 6'd6) begin
            errors++;
            $display("FAIL br_rel_neg: pc=%0d want 6", pc);
        end
        jump(6'd62);
        step();
        checks++;
        if (pc !== 6'd63) begin
            errors++;
            $display("FAIL inc_63: pc=%0d want 63", pc);
        end
        step();
        checks++;
        if (pc !== 6'd0) begin
            errors++;
            $display("FAIL inc_wrap: pc=%0d want 0", pc);
        end
        jump(6'd62);
        branch_en = 1'b1;
        rel_mode  = 1'b1;
        offset    = 6'd3;
        step();
        idle();
        checks++;
        if (pc !== 6'd1) begin
            errors++;
            $display("FAIL br_rel_wrap: pc=%0d want 1", pc);
        end
    endtask

    task automatic test_call_ret();
        do_reset();
        jump(6'd5);
        call(6'd20);
        checks++;
        if (pc !== 6'd20 || ras_count !== 3'd1) begin
            errors++;
            $display("FAIL call1: pc=%0d cnt=%0d want 20 1", pc, ras_count);
        end
        call(6'd40);
        checks++;
        if (pc !== 6'd40 || ras_count !== 3'd2) begin
            errors++;
            $display("FAIL call2: pc=%0d cnt=%0d want 40 2", pc, ras_count);
        end
        ret();
        checks++;
        if (pc !== 6'd21 || ras_count !== 3'd1) begin
            errors++;
            $display("FAIL ret1: pc=%0d cnt=%0d want 21 1", pc, ras_count);
        end
        ret();
        checks++;
        if (pc !== 6'd6 || ras_count !== 3'd0 || ras_empty !== 1'b1 || ras_unf !== 1'b0) begin
            errors++;
            $display("FAIL ret2: pc=%0d cnt=%0d e=%b u=%b want 6 0 1 0",
                     pc, ras_count, ras_empty, ras_unf);
        end
    endtask

    task automatic test_overflow();
        logic [5:0] exp_ret [4];
        exp_ret[0] = 6'd42;
        exp_ret[1] = 6'd32;
        exp_ret[2] = 6'd22;
        exp_ret[3] = 6'd12;
        do_reset();
        jump(6'd1);
        for (int i = 0; i < 5; i++) begin
            call(6'(1 + 10 * i + 10));
        end
        checks++;
        if (pc !== 6'd51 || ras_count !== 3'd4 || ras_full !== 1'b1 || ras_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf: pc=%0d cnt=%0d f=%b o=%b want 51 4 1 1",
                     pc, ras_count, ras_full, ras_ovf);
        end
        for (int i = 0; i < 4; i++) begin
            ret();
            checks++;
            if (pc !== exp_ret[i] || ras_count !== 3'(3 - i)) begin
                errors++;
                $display("FAIL ovf_ret%0d: pc=%0d cnt=%0d want %0d %0d",
                         i, pc, ras_count, exp_ret[i], 3 - i);
            end
        end
        ret();
        checks++;
        if (pc !== 6'd13 || ras_unf !== 1'b1 || ras_count !== 3'd0 || ras_ovf !== 1'b1) begin
            errors++;
            $display("FAIL unf: pc=%0d u=%b cnt=%0d o=%b want 13 1 0 1",
                     pc, ras_unf, ras_count, ras_ovf);
        end
    endtask

    task automatic test_stall();
        do_reset();
        jump(6'd7);
        call(6'd30);
        pc_en         = 1'b0;
        branch_en     = 1'b1;
        call_en       = 1'b1;
        branch_target = 6'd50;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (pc !== 6'd30 || ras_count !== 3'd1) begin
                errors++;
                $display("FAIL stall%0d: pc=%0d cnt=%0d want 30 1", i, pc, ras_count);
            end
        end
        idle();
        pc_en = 1'b1;
        ret();
        checks++;
        if (pc !== 6'd8) begin
            errors++;
            $display("FAIL stall_ret: pc=%0d want 8", pc);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        call(6'd10);
        call(6'd20);
        call(6'd30);
        checks++;
        if (ras_count !== 3'd3 || pc !== 6'd30) begin
            errors++;
            $display("FAIL chain: pc=%0d cnt=%0d want 30 3", pc, ras_count);
        end
        do_reset();
        checks++;
        if (pc !== 6'd0 || ras_count !== 3'd0 || ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: pc=%0d cnt=%0d o=%b u=%b want 0 0 0 0",
                     pc, ras_count, ras_ovf, ras_unf);
        end
        call_en       = 1'b1;
        ret_en        = 1'b1;
        branch_target = 6'd50;
        step();
        idle();
        checks++;
        if (pc !== 6'd1 || ras_unf !== 1'b1 || ras_count !== 3'd0) begin
            errors++;
            $display("FAIL call_ret_both: pc=%0d u=%b cnt=%0d want 1 1 0",
                     pc, ras_unf, ras_count);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        pc_en  = 1'b0;
        idle();
        step();
        test_reset();
        test_branch();
        test_call_ret();
        test_overflow();
        test_stall();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
